// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command path.
// Used by the command sequencer and the serial CRC7 generator.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SEND,
        WAIT,
        RECV,
        BUSYW,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        RESP_R1   = 2'd0,
        RESP_R1B  = 2'd1,
        RESP_R3R7 = 2'd2,
        RESP_RSVD = 2'd3
    } resp_type_e;

    localparam logic [6:0]  CRC7_POLY    = 7'h09;
    localparam logic [1:0]  FRAME_START  = 2'b01;
    localparam logic        FRAME_STOP   = 1'b1;
    localparam logic [39:0] TIMEOUT_RESP = 40'hFF_FFFF_FFFF;

    localparam int FRAME_BITS = 48;
    localparam int HDR_BITS   = 40;
    localparam int R1_BITS    = 8;
    localparam int R3_BITS    = 40;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, zero seed.
// Shared by the command frame path and the data-block path.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] r_crc;
    logic       w_fb;

    assign w_fb = bit_in ^ r_crc[6];

    // NOTE: sequential state is only ever written with <= so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc <= '0;
        end else if (clear) begin
            r_crc <= '0;
        end else if (enable) begin
            r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sd_cmd_seq.sv
// SD SPI-mode command engine: pre-clocks, 48-bit frame with CRC7, response
// capture (R1/R1b/R3/R7) and automatic retry on response timeout.
module sd_cmd_seq
    import sd_pkg::*;
#(
    parameter int PRE_BITS  = 8,
    parameter int TIMEOUT   = 2000,
    parameter int MAX_RETRY = 3,
    parameter int RW        = $clog2(MAX_RETRY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    index,
    input  logic [31:0]   argument,
    input  logic [1:0]    resp_type,
    input  logic          start,
    output logic          busy,
    output logic          finish,
    output logic          error,
    output logic [RW-1:0] retries,
    output logic          DI,
    input  logic          DO,
    output logic [39:0]   response
);

    localparam int CNT_A   = (TIMEOUT > PRE_BITS) ? TIMEOUT : PRE_BITS;
    localparam int CNT_MAX = (CNT_A > FRAME_BITS) ? CNT_A : FRAME_BITS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_BITS - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SEND_CRC  = CW'(HDR_BITS);
    localparam logic [CW-1:0] SEND_STOP = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] SEND_END  = CW'(FRAME_BITS);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_e        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [39:0]   r_hdr, w_hdr_nxt;
    resp_type_e    r_rtype, w_rtype_nxt;
    logic [38:0]   r_sh, w_sh_nxt;
    logic [39:0]   r_response, w_resp_nxt;
    logic          r_error, w_err_nxt;
    logic [RW-1:0] r_retries, w_retries_nxt;
    logic          r_di, w_di_nxt;

    logic          w_crc_en;
    logic          w_crc_clr;
    logic [6:0]    w_crc;
    logic [5:0]    w_hdr_idx;
    logic [2:0]    w_crc_idx;
    logic [CW-1:0] w_recv_last;

    assign w_crc_clr   = (r_state != SEND);
    assign w_hdr_idx   = 6'(6'd39 - r_cnt[5:0]);
    assign w_crc_idx   = 3'(6'd46 - r_cnt[5:0]);
    assign w_recv_last = (r_rtype == RESP_R3R7) ? CW'(R3_BITS - 1) : CW'(R1_BITS - 1);

    sd_crc7 u_crc7 (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_crc_clr),
        .enable (w_crc_en),
        .bit_in (r_hdr[w_hdr_idx]),
        .crc    (w_crc)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hdr_nxt     = r_hdr;
        w_rtype_nxt   = r_rtype;
        w_sh_nxt      = r_sh;
        w_resp_nxt    = r_response;
        w_err_nxt     = r_error;
        w_retries_nxt = r_retries;
        w_di_nxt      = 1'b1;
        w_crc_en      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_hdr_nxt     = {FRAME_START, index, argument};
                    w_rtype_nxt   = resp_type_e'(resp_type);
                    w_retries_nxt = '0;
                    w_err_nxt     = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = PRE;
                end
            end
            PRE: begin
                if (r_cnt == PRE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = SEND;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            SEND: begin
                // DI is registered, so the bit chosen at count c appears one cycle later;
                // count 48 leaves the stop bit on the line for its full cycle.
                if (r_cnt < SEND_CRC) begin
                    w_di_nxt = r_hdr[w_hdr_idx];
                    w_crc_en = 1'b1;
                end else if (r_cnt < SEND_STOP) begin
                    w_di_nxt = w_crc[w_crc_idx];
                end else if (r_cnt == SEND_STOP) begin
                    w_di_nxt = FRAME_STOP;
                end
                if (r_cnt == SEND_END) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT: begin
                if (!DO) begin
                    w_sh_nxt    = '0;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = RECV;
                end else if (r_cnt == TO_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retries < RETRY_MAX) begin
                        w_retries_nxt = r_retries + 1'b1;
                        w_state_nxt   = PRE;
                    end else begin
                        w_resp_nxt  = TIMEOUT_RESP;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RECV: begin
                w_sh_nxt  = {r_sh[37:0], DO};
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == w_recv_last) begin
                    w_resp_nxt  = {r_sh, DO};
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_rtype == RESP_R1B) ? BUSYW : DONE;
                end
            end
            BUSYW: begin
                if (DO) begin
                    w_state_nxt = DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hdr      <= '0;
            r_rtype    <= RESP_R1;
            r_sh       <= '0;
            r_response <= '0;
            r_error    <= 1'b0;
            r_retries  <= '0;
            r_di       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hdr      <= w_hdr_nxt;
            r_rtype    <= w_rtype_nxt;
            r_sh       <= w_sh_nxt;
            r_response <= w_resp_nxt;
            r_error    <= w_err_nxt;
            r_retries  <= w_retries_nxt;
            r_di       <= w_di_nxt;
        end
    end

    assign busy     = (r_state != IDLE);
    assign finish   = (r_state == DONE);
    assign error    = r_error;
    assign retries  = r_retries;
    assign DI       = r_di;
    assign response = r_response;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Self-checking bench for sd_cmd_seq: a cycle-indexed card/transaction model
// built from the timing rules, compared against DUT outputs every cycle.
module tb_sd_cmd_seq;

    localparam int P    = 8;
    localparam int T    = 64;
    localparam int MR   = 3;
    localparam int MAXC = 2048;

    logic        clk;
    logic        reset;
    logic [5:0]  index;
    logic [31:0] argument;
    logic [1:0]  resp_type;
    logic        start;
    logic        busy;
    logic        finish;
    logic        error;
    logic [1:0]  retries;
    logic        DI;
    logic        DO;
    logic [39:0] response;

    sd_cmd_seq #(
        .PRE_BITS  (P),
        .TIMEOUT   (T),
        .MAX_RETRY (MR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .index     (index),
        .argument  (argument),
        .resp_type (resp_type),
        .start     (start),
        .busy      (busy),
        .finish    (finish),
        .error     (error),
        .retries   (retries),
        .DI        (DI),
        .DO        (DO),
        .response  (response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit          exp_di  [MAXC];
    bit          do_plan [MAXC];
    int          exp_done;
    int          exp_retries;
    logic [39:0] exp_resp;
    logic        exp_err;

    int          cyc;
    bit          tr_active;
    logic [47:0] frame_cap;
    int          fin_cycle;
    bit          cmp_busy;
    bit          cmp_fin;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] crc7_of(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // lat[a]: WAIT cycles of DO=1 before the start bit on attempt a (<0 = silent).
    task automatic plan(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input int lat [4], input logic [39:0] card_resp, input int busy_len);
        logic [47:0] fr;
        int          len, b, w, s, r_end;
        bit          got;
        fr  = {2'b01, idx, arg, crc7_of({2'b01, idx, arg}), 1'b1};
        len = (rt == 2'd2) ? 40 : 8;
        for (int k = 0; k < MAXC; k++) begin
            exp_di[k]  = 1'b1;
            do_plan[k] = 1'b1;
        end
        b   = 0;
        got = 1'b0;
        for (int a = 0; a <= MR; a++) begin
            for (int i = 0; i < 48; i++) exp_di[b + P + 1 + i] = fr[47 - i];
            w = b + P + 49;
            if (lat[a] >= 0 && lat[a] < T) begin
                s = w + lat[a];
                for (int i = 0; i < len; i++) do_plan[s + i] = card_resp[len - 1 - i];
                r_end       = s + len - 1;
                exp_retries = a;
                exp_resp    = (len == 8) ? {32'h0, card_resp[7:0]} : card_resp;
                exp_err     = 1'b0;
                exp_done    = r_end + 1;
                if (rt == 2'd1) begin
                    for (int m = 0; m < busy_len; m++) do_plan[r_end + 1 + m] = 1'b0;
                    if (busy_len >= T) begin
                        exp_done = r_end + 1 + T;
                        exp_err  = 1'b1;
                    end else begin
                        exp_done = r_end + 2 + busy_len;
                    end
                end
                got = 1'b1;
                break;
            end
            b = w + T;
        end
        if (!got) begin
            exp_done    = b;
            exp_resp    = 40'hFF_FFFF_FFFF;
            exp_err     = 1'b1;
            exp_retries = MR;
        end
    endtask

    always @(negedge clk) begin
        if (tr_active) begin
            cmp_busy = (cyc <= exp_done + 3);
            cmp_fin  = (cyc >= exp_done) && (cyc <= exp_done + 3);
            check($sformatf("cyc%0d di/busy/finish", cyc), {61'h0, DI, busy, finish},
                  {61'h0, exp_di[cyc], cmp_busy, cmp_fin});
            if (cyc >= P + 1 && cyc <= P + 48) frame_cap = {frame_cap[46:0], DI};
            if (finish && fin_cycle < 0) fin_cycle = cyc;
        end
    end

    task automatic run_txn(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] rt, input int lat [4],
                           input logic [39:0] card_resp, input int busy_len);
        int last;
        plan(idx, arg, rt, lat, card_resp, busy_len);
        last      = exp_done + 5;
        frame_cap = '0;
        fin_cycle = -1;
        @(negedge clk);
        index     = idx;
        argument  = arg;
        resp_type = rt;
        start     = 1'b1;
        @(posedge clk);
        #1;
        cyc       = 0;
        tr_active = 1'b1;
        DO        = do_plan[0];
        index     = ~idx;
        argument  = ~arg;
        resp_type = ~rt;
        while (cyc < last) begin
            @(posedge clk);
            #1;
            cyc++;
            DO = do_plan[cyc];
            if (cyc == exp_done + 3) start = 1'b0;
        end
        @(posedge clk);
        #1;
        tr_active = 1'b0;
        DO        = 1'b1;
        check({tag, " response"}, {24'h0, response}, {24'h0, exp_resp});
        check({tag, " error"}, {63'h0, error}, {63'h0, exp_err});
        check({tag, " retries"}, 64'(retries), 64'(exp_retries));
        check({tag, " finish cycle"}, 64'(fin_cycle), 64'(exp_done));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        index     = '0;
        argument  = '0;
        resp_type = '0;
        DO        = 1'b1;
        tr_active = 1'b0;
        cyc       = 0;
        fin_cycle = -1;
        frame_cap = '0;

        #12;
        check("reset DI", {63'h0, DI}, 64'h1);
        check("reset busy/finish/error", {61'h0, busy, finish, error}, 64'h0);
        check("reset retries", 64'(retries), 64'h0);
        check("reset response", {24'h0, response}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        run_txn("cmd0", 6'd0, 32'h0, 2'd0, '{3, -1, -1, -1}, 40'h01, 0);
        check("cmd0 frame", {16'h0, frame_cap}, 64'h4000_0000_0095);
        check("cmd0 finish literal", 64'(fin_cycle), 64'd68);

        run_txn("cmd8", 6'd8, 32'h0000_01AA, 2'd2, '{0, -1, -1, -1}, 40'h01_0000_01AA, 0);
        check("cmd8 frame", {16'h0, frame_cap}, 64'h4800_0001_AA87);
        check("cmd8 response literal", {24'h0, response}, 64'h01_0000_01AA);
        check("cmd8 finish literal", 64'(fin_cycle), 64'd97);

        run_txn("silent", 6'd0, 32'h0, 2'd0, '{-1, -1, -1, -1}, 40'h0, 0);
        check("silent response literal", {24'h0, response}, 64'hFF_FFFF_FFFF);
        check("silent retries literal", 64'(retries), 64'd3);
        check("silent finish literal", 64'(fin_cycle), 64'd484);

        run_txn("retry1", 6'd17, 32'h0000_1234, 2'd0, '{-1, T - 1, -1, -1}, 40'h00, 0);
        check("retry1 retries literal", 64'(retries), 64'd1);
        check("retry1 finish literal", 64'(fin_cycle), 64'd249);

        run_txn("r1b", 6'd12, 32'h0, 2'd1, '{1, -1, -1, -1}, 40'h00, 50);
        check("r1b finish literal", 64'(fin_cycle), 64'd117);

        run_txn("r1b_to", 6'd12, 32'h0, 2'd1, '{1, -1, -1, -1}, 40'h00, T + 10);
        check("r1b_to error literal", {63'h0, error}, 64'h1);

        run_txn("rsvd", 6'd13, 32'hCAFE_0001, 2'd3, '{2, -1, -1, -1}, 40'h05, 0);

        @(negedge clk);
        index     = 6'd17;
        argument  = 32'h0000_DEAD;
        resp_type = 2'd0;
        start     = 1'b1;
        repeat (P + 20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midsend reset DI/busy/finish", {61'h0, DI, busy, finish}, 64'h4);
        check("midsend reset response", {24'h0, response}, 64'h0);
        check("midsend reset error/retries", {61'h0, error, retries}, 64'h0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        run_txn("fresh", 6'd0, 32'h0, 2'd0, '{3, -1, -1, -1}, 40'h01, 0);
        check("fresh frame", {16'h0, frame_cap}, 64'h4000_0000_0095);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_cmd_seq.md
# sd_cmd_seq

Parametrised SD (SPI-mode) command transaction engine: serialises one 48-bit command frame with on-the-fly CRC7, waits for the card's response start bit, captures an R1, R1b or 40-bit R3/R7 response, and retries automatically on response timeout. It sits between the card-init/block-transfer controllers and the SD pins. It replaces the fixed-length command/response pair with one engine that has configurable pre-clocks, timeout and retry count.

## Interface
Parameters:
- PRE_BITS, 8: DI-high idle clocks sent before every frame attempt (≥1).
- TIMEOUT, 2000: max clocks to wait for response start bit, and for R1b busy release.
- MAX_RETRY, 3: extra attempts after a timeout (0 = single attempt).
- RW, $clog2(MAX_RETRY+1): width of retries output.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  SD/SPI bit clock; one bit per cycle each way.
- reset  in  1  asynchronous active-high reset.
- index  in  6  command index; sampled with start.
- argument  in  32  command argument; sampled with start.
- resp_type  in  2  0=R1 (8 b), 1=R1b (8 b + busy), 2=R3/R7 (40 b), 3=reserved (treated as R1); sampled with start.
- start  in  1  level request; accepted only in IDLE.
- busy  out  1  high in every state except IDLE.
- finish  out  1  high only in DONE.
- error  out  1  valid while finish; 1 = all attempts timed out or busy timeout.
- retries  out  RW  attempts beyond the first used by the last transaction.
- DI  out  1  card data-in (MOSI); registered; 1 when not sending frame bits.
- DO  in  1  card data-out (MISO).
- response  out  40  R1/R1b right-aligned in [7:0], [39:8]=0; R3/R7 full 40 b; 40'hFF_FFFF_FFFF on timeout.

## Operation
- Frame: bits 47..0 = 0,1,index[5:0],argument[31:0],crc7[6:0],1; sent MSB first. CRC7 polynomial x^7+x^3+1, zero initial, computed over bits 47..8.
- IDLE: busy=0, finish=0, DI=1. On start=1, latch index/argument/resp_type, clear retries/error, go to PRE.
- PRE: DI=1 for PRE_BITS cycles, then go to SEND.
- SEND: 48 cycles, one frame bit per cycle; clear the CRC at entry.
- WAIT: DI=1; sample DO each cycle. On DO=0, capture that bit as response MSB and go to RECV. After TIMEOUT cycles with DO=1:
  - if retries<MAX_RETRY: retries+1, go to PRE.
  - else: response=all ones, error=1, go to DONE.
- RECV: shift DO in MSB first until 8 (R1/R1b) or 40 (R3/R7) bits total, including the start bit.
  - R1b goes to BUSYW.
  - Others go to DONE.
- BUSYW: wait for DO=1, then go to DONE. After TIMEOUT cycles with DO=0: error=1, keep the captured R1, go to DONE.
- DONE: finish=1, busy=1. Hold response/error/retries until start=0, then go to IDLE. Outputs remain valid until the next accepted start.
- No retry on R1 error bits; these are reported as-is.
- reset at any time: state IDLE, DI=1, busy=0, finish=0, error=0, retries=0, response=0, CRC cleared. A frame in flight is abandoned.

## Timing
- start sampled high at edge N: busy=1 after edge N; DI=1 for PRE_BITS cycles; frame bit 47 on DI after edge N+PRE_BITS+1.
- The last frame bit (stop bit) is driven for one cycle, then WAIT begins. A DO=0 on the first WAIT sample is a valid start bit (Ncr=0).
- Best-case R1 completion: finish high PRE_BITS+48+8+1 cycles after the start edge.
- Timeout triggers on the TIMEOUT-th consecutive WAIT cycle. DO=0 in that same cycle wins over timeout.
- start held high through DONE does not restart; a new transaction requires start low for ≥1 cycle.
- Changes on index/argument/resp_type after acceptance have no effect.

## Structure
- Package sd_pkg:
  - state enum (IDLE, PRE, SEND, WAIT, RECV, BUSYW, DONE)
  - resp_type codes
  - CRC7 polynomial 7'h09
  - frame start/stop constants
  - TIMEOUT_RESP = 40'hFF_FFFF_FFFF
- Sub-module sd_crc7: serial CRC7 with clear, enable, bit_in inputs and a 7-bit crc output. Reused later by the data-block path.

## Test plan
- CMD0, argument 0, R1; card answers 0x01 after 3 cycles. Required: DI frame 0x40_00_00_00_00_95, response=0x01, error=0, retries=0.
- CMD8, argument 0x1AA, R7; card answers 0x01_000001AA. Required: frame ends CRC byte 0x87, response=40'h01_0000_01AA.
- CMD0 with DO stuck high, MAX_RETRY=3. Required: 4 frames separated by PRE_BITS DI-high gaps, response all ones, error=1, retries=3.
- Card silent on the first attempt, answers 0x00 on the second. Required: retries=1, error=0, response=0x00.
- R1b answer 0x00, then DO low for 50 cycles. Required: finish rises 1 cycle after DO returns high. With DO low for TIMEOUT cycles: error=1, response=0x00.
- reset asserted mid-SEND: DI=1 and busy=0 immediately. A new start then produces a complete fresh frame.
